// File: rtl/colorbar_timing_gen.sv
// colorbar_timing_gen
// Free-running 640x480 video timing generator with an 8-bar colour pattern.
// Produces active-low hsync/vsync, data enable and a 24-bit RGB pixel, all
// registered, one clock behind the scan counters.
// Optional feature macro: COLORBAR_TIMING_GEN_RAMP_EN -- when defined, the
// bottom quarter of the active lines shows a grey ramp instead of bars.
module colorbar_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clock,
  input  logic        reset,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out,
  output logic [23:0] pixel_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BAR_CW  = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  // Boundaries sized to the counters so every compare is width-matched.
  localparam logic [10:0] H_ACT_C      = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG_C = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END_C = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_LAST_C     = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_ACT_C      = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SYNC_BEG_C = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  V_SYNC_END_C = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  V_LAST_C     = 10'(V_TOTAL - 1);
  localparam logic [BAR_CW-1:0] BAR_LAST_C = BAR_CW'(BAR_W - 1);

`ifdef COLORBAR_TIMING_GEN_RAMP_EN
  localparam logic [9:0]  V_RAMP_C     = 10'(V_ACTIVE * 3 / 4);
`endif

  // Scan state
  logic [10:0]       h_count_reg, h_count_next;
  logic [9:0]        v_count_reg, v_count_next;
  logic [BAR_CW-1:0] bar_sub_reg, bar_sub_next;
  logic [2:0]        bar_idx_reg, bar_idx_next;

  // Registered outputs
  logic              hsync_reg, hsync_next;
  logic              vsync_reg, vsync_next;
  logic              de_reg, de_next;
  logic [23:0]       pixel_reg, pixel_next;

  logic              h_wrap;
  logic              v_wrap;
  logic              active;

  // Colour of each bar: R off for idx bit1, G off for idx bit2, B off for idx bit0.
  logic [23:0] bar_color [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_bar_color
      localparam logic [2:0] IDX = 3'(gi);
      assign bar_color[gi] = {{8{~IDX[1]}}, {8{~IDX[2]}}, {8{~IDX[0]}}};
    end
  endgenerate

  // Region decode of the current scan position.
  always_comb begin
    h_wrap = (h_count_reg == H_LAST_C);
    v_wrap = (v_count_reg == V_LAST_C);
    active = (h_count_reg < H_ACT_C) && (v_count_reg < V_ACT_C);
  end

  // Next scan position: h wraps every line, v advances on the h wrap.
  always_comb begin
    h_count_next = h_wrap ? 11'd0 : h_count_reg + 11'd1;
    v_count_next = v_count_reg;
    if (h_wrap) begin
      v_count_next = v_wrap ? 10'd0 : v_count_reg + 10'd1;
    end
  end

  // Bar tracking without a divider: sub-counter over BAR_W pixels drives the index.
  always_comb begin
    bar_sub_next = bar_sub_reg;
    bar_idx_next = bar_idx_reg;
    if (h_wrap) begin
      bar_sub_next = '0;
      bar_idx_next = 3'd0;
    end else if (active) begin
      if (bar_sub_reg == BAR_LAST_C) begin
        bar_sub_next = '0;
        bar_idx_next = bar_idx_reg + 3'd1;
      end else begin
        bar_sub_next = bar_sub_reg + BAR_CW'(1);
      end
    end
  end

  // Output values for the position currently held in the counters.
  always_comb begin
    hsync_next = ~((h_count_reg >= H_SYNC_BEG_C) && (h_count_reg < H_SYNC_END_C));
    vsync_next = ~((v_count_reg >= V_SYNC_BEG_C) && (v_count_reg < V_SYNC_END_C));
    de_next    = active;
    pixel_next = 24'h000000;
    if (active) begin
      pixel_next = bar_color[bar_idx_reg];
`ifdef COLORBAR_TIMING_GEN_RAMP_EN
      if (v_count_reg >= V_RAMP_C) begin
        pixel_next = {3{h_count_reg[9:2]}};
      end
`endif
    end
  end

  // State and output registers; reset parks the scan at (0,0) with blank outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_count_reg <= 11'd0;
      v_count_reg <= 10'd0;
      bar_sub_reg <= '0;
      bar_idx_reg <= 3'd0;
      hsync_reg   <= 1'b1;
      vsync_reg   <= 1'b1;
      de_reg      <= 1'b0;
      pixel_reg   <= 24'h000000;
    end else begin
      h_count_reg <= h_count_next;
      v_count_reg <= v_count_next;
      bar_sub_reg <= bar_sub_next;
      bar_idx_reg <= bar_idx_next;
      hsync_reg   <= hsync_next;
      vsync_reg   <= vsync_next;
      de_reg      <= de_next;
      pixel_reg   <= pixel_next;
    end
  end

  assign hsync_out = hsync_reg;
  assign vsync_out = vsync_reg;
  assign de_out    = de_reg;
  assign pixel_out = pixel_reg;

endmodule

// File: tb/tb_colorbar_timing_gen.sv
// tb_colorbar_timing_gen
// Self-checking bench for colorbar_timing_gen. Horizontal geometry is the
// standard 640-pixel line; the vertical geometry is shortened so whole
// frames stay short. Expected outputs come from a position-based model:
// the n-th edge after reset release shows scan position n (h = n mod H_TOTAL).
module tb_colorbar_timing_gen;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 8;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME    = H_TOTAL * V_TOTAL;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        hsync_out;
  logic        vsync_out;
  logic        de_out;
  logic [23:0] pixel_out;

  int checks = 0;
  int errors = 0;
  int pos    = 0;   // scan position the next clock edge will present
  int cur    = 0;   // scan position presented by the most recent edge

  logic [23:0] bar_lut [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                               24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  colorbar_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .hsync_out(hsync_out),
    .vsync_out(vsync_out),
    .de_out   (de_out),
    .pixel_out(pixel_out)
  );

  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected {hsync, vsync, de, pixel} for an absolute position since release.
  function automatic logic [26:0] model(input int t);
    int h;
    int v;
    logic hs;
    logic vs;
    logic de;
    logic [23:0] px;
    logic [7:0] g;
    h  = t % H_TOTAL;
    v  = (t / H_TOTAL) % V_TOTAL;
    hs = !(h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC);
    vs = !(v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC);
    de = (h < H_ACTIVE) && (v < V_ACTIVE);
    px = 24'h000000;
    if (de) begin
      px = bar_lut[h / (H_ACTIVE / 8)];
`ifdef COLORBAR_TIMING_GEN_RAMP_EN
      if (v >= V_ACTIVE * 3 / 4) begin
        g  = 8'((h / 4) % 256);
        px = {g, g, g};
      end
`endif
    end
    g = 8'h00;
    return {hs, vs, de, px};
  endfunction

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
    cur = pos;
    pos = pos + 1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (hsync_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_hsync got %b want 1", hsync_out);
    end
    checks++;
    if (vsync_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_vsync got %b want 1", vsync_out);
    end
    checks++;
    if (de_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_de got %b want 0", de_out);
    end
    checks++;
    if (pixel_out !== 24'h000000) begin
      errors++;
      $display("FAIL reset_pixel got %h want 000000", pixel_out);
    end
    @(negedge clock);
    reset = 1'b0;
    pos   = 0;
  endtask

  task automatic test_first_edge();
    tick();
    checks++;
    if (de_out !== 1'b1) begin
      errors++;
      $display("FAIL first_edge_de got %b want 1", de_out);
    end
    checks++;
    if (pixel_out !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL first_edge_pixel got %h want FFFFFF", pixel_out);
    end
  endtask

  // Remaining sample points of line 0 against the published bar colours.
  task automatic test_bars();
    int idx [9] = '{79, 80, 160, 240, 320, 400, 480, 560, 639};
    logic [23:0] want [9] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00, 24'hFF00FF,
                              24'hFF0000, 24'h0000FF, 24'h000000, 24'h000000};
    int k;
    k = 0;
    while (cur < H_TOTAL - 1) begin
      tick();
      if (k < 9 && cur == idx[k]) begin
        checks++;
        if (pixel_out !== want[k]) begin
          errors++;
          $display("FAIL bar_pixel h=%0d got %h want %h", cur, pixel_out, want[k]);
        end
        k++;
      end
    end
  endtask

  task automatic test_line_timing();
    int t_de_rise;
    int t_hs_fall;
    int t_hs_rise;
    int t_de_rise2;
    int de_cnt;
    logic pde;
    logic phs;
    t_de_rise  = -1;
    t_hs_fall  = -1;
    t_hs_rise  = -1;
    t_de_rise2 = -1;
    de_cnt     = 0;
    pde        = de_out;
    phs        = hsync_out;
    for (int i = 0; i < 2000 && t_de_rise2 < 0; i++) begin
      tick();
      if (de_out && !pde) begin
        if (t_de_rise < 0) t_de_rise = cur;
        else t_de_rise2 = cur;
      end
      if (t_de_rise >= 0 && t_de_rise2 < 0 && de_out) de_cnt++;
      if (t_de_rise >= 0 && t_hs_fall < 0 && !hsync_out && phs) t_hs_fall = cur;
      if (t_hs_fall >= 0 && t_hs_rise < 0 && hsync_out && !phs) t_hs_rise = cur;
      pde = de_out;
      phs = hsync_out;
    end
    checks++;
    if (t_de_rise2 < 0) begin
      errors++;
      $display("FAIL line_timeout got no second de rise want one within 2000 clocks");
    end
    checks++;
    if (de_cnt !== H_ACTIVE) begin
      errors++;
      $display("FAIL de_width got %0d want %0d", de_cnt, H_ACTIVE);
    end
    checks++;
    if (t_hs_fall - t_de_rise !== H_ACTIVE + H_FP) begin
      errors++;
      $display("FAIL de_to_hsync got %0d want %0d", t_hs_fall - t_de_rise, H_ACTIVE + H_FP);
    end
    checks++;
    if (t_hs_rise - t_hs_fall !== H_SYNC) begin
      errors++;
      $display("FAIL hsync_width got %0d want %0d", t_hs_rise - t_hs_fall, H_SYNC);
    end
    checks++;
    if (t_de_rise2 - t_de_rise !== H_TOTAL) begin
      errors++;
      $display("FAIL line_period got %0d want %0d", t_de_rise2 - t_de_rise, H_TOTAL);
    end
  endtask

  // Two full frames: every pixel against the model, plus frame-level timing.
  task automatic test_frames();
    int start;
    int f;
    int nfall;
    int vs_fall [2];
    int vs_low [2];
    int de_lines [2];
    int line_bad;
    int bad_h;
    logic [26:0] exp_v;
    logic [26:0] got_v;
    logic [26:0] bad_got;
    logic [26:0] bad_exp;
    logic pvs;
    logic line_de;
    nfall    = 0;
    vs_fall  = '{-1, -1};
    vs_low   = '{0, 0};
    de_lines = '{0, 0};
    line_bad = 0;
    bad_h    = 0;
    bad_got  = '0;
    bad_exp  = '0;
    line_de  = 1'b0;
    for (int i = 0; i < FRAME && (pos % FRAME) != 0; i++) tick();
    start = pos;
    pvs   = vsync_out;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      f     = (cur - start) / FRAME;
      exp_v = model(cur);
      got_v = {hsync_out, vsync_out, de_out, pixel_out};
      if (got_v !== exp_v) begin
        if (line_bad == 0) begin
          bad_h   = cur % H_TOTAL;
          bad_got = got_v;
          bad_exp = exp_v;
        end
        line_bad++;
      end
      if (de_out) line_de = 1'b1;
      if (!vsync_out) vs_low[f]++;
      if (!vsync_out && pvs && nfall < 2) begin
        vs_fall[nfall] = cur - start;
        nfall++;
      end
      pvs = vsync_out;
`ifdef COLORBAR_TIMING_GEN_RAMP_EN
      if (f == 0 && (cur / H_TOTAL) % V_TOTAL == V_ACTIVE * 3 / 4) begin
        if (cur % H_TOTAL == 0 || cur % H_TOTAL == 4 || cur % H_TOTAL == 639) begin
          checks++;
          if (pixel_out !== {3{8'((cur % H_TOTAL) / 4)}}) begin
            errors++;
            $display("FAIL ramp_pixel h=%0d got %h want %h", cur % H_TOTAL, pixel_out,
                     {3{8'((cur % H_TOTAL) / 4)}});
          end
        end
      end
      if (f == 0 && (cur / H_TOTAL) % V_TOTAL == V_ACTIVE * 3 / 4 - 1 && cur % H_TOTAL == 80) begin
        checks++;
        if (pixel_out !== 24'hFFFF00) begin
          errors++;
          $display("FAIL pre_ramp_bar got %h want FFFF00", pixel_out);
        end
      end
`endif
      if (cur % H_TOTAL == H_TOTAL - 1) begin
        checks++;
        if (line_bad !== 0) begin
          errors++;
          $display("FAIL frame_line v=%0d bad=%0d first h=%0d got %h want %h",
                   (cur / H_TOTAL) % V_TOTAL, line_bad, bad_h, bad_got, bad_exp);
        end
        if (line_de) de_lines[f]++;
        line_bad = 0;
        line_de  = 1'b0;
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (de_lines[k] !== V_ACTIVE) begin
        errors++;
        $display("FAIL de_lines frame=%0d got %0d want %0d", k, de_lines[k], V_ACTIVE);
      end
      checks++;
      if (vs_low[k] !== V_SYNC * H_TOTAL) begin
        errors++;
        $display("FAIL vsync_low frame=%0d got %0d want %0d", k, vs_low[k], V_SYNC * H_TOTAL);
      end
    end
    checks++;
    if (vs_fall[0] !== (V_ACTIVE + V_FP) * H_TOTAL) begin
      errors++;
      $display("FAIL vsync_start got %0d want %0d", vs_fall[0], (V_ACTIVE + V_FP) * H_TOTAL);
    end
    checks++;
    if (vs_fall[1] - vs_fall[0] !== FRAME) begin
      errors++;
      $display("FAIL frame_period got %0d want %0d", vs_fall[1] - vs_fall[0], FRAME);
    end
  endtask

  // Assert reset between edges at a chosen scan position, then re-check a line.
  task automatic test_mid_reset(input int th, input int tv, input int hold);
    int target;
    int de_cnt;
    int line_bad;
    logic [26:0] exp_v;
    target = tv * H_TOTAL + th;
    for (int i = 0; i < FRAME + 1 && (pos % FRAME) != target; i++) tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({hsync_out, vsync_out, de_out, pixel_out} !== {1'b1, 1'b1, 1'b0, 24'h000000}) begin
      errors++;
      $display("FAIL async_reset h=%0d v=%0d got %b%b%b %h want 110 000000",
               th, tv, hsync_out, vsync_out, de_out, pixel_out);
    end
    repeat (hold) @(posedge clock);
    #1;
    checks++;
    if ({hsync_out, vsync_out, de_out, pixel_out} !== {1'b1, 1'b1, 1'b0, 24'h000000}) begin
      errors++;
      $display("FAIL reset_hold clocks=%0d got %b%b%b %h want 110 000000",
               hold, hsync_out, vsync_out, de_out, pixel_out);
    end
    @(negedge clock);
    reset = 1'b0;
    pos   = 0;
    de_cnt   = 0;
    line_bad = 0;
    for (int i = 0; i < H_TOTAL; i++) begin
      tick();
      if (i == 0) begin
        checks++;
        if (de_out !== 1'b1 || pixel_out !== 24'hFFFFFF) begin
          errors++;
          $display("FAIL restart_first got de=%b %h want de=1 FFFFFF", de_out, pixel_out);
        end
      end
      if (de_out) de_cnt++;
      exp_v = model(cur);
      if ({hsync_out, vsync_out, de_out, pixel_out} !== exp_v) line_bad++;
    end
    checks++;
    if (de_cnt !== H_ACTIVE) begin
      errors++;
      $display("FAIL restart_de_burst got %0d want %0d", de_cnt, H_ACTIVE);
    end
    checks++;
    if (line_bad !== 0) begin
      errors++;
      $display("FAIL restart_line got %0d bad pixels want 0", line_bad);
    end
  endtask

  initial begin
    test_reset();
    test_first_edge();
    test_bars();
    test_line_timing();
    test_frames();
    test_mid_reset(300, V_ACTIVE / 2, 3);
    for (int r = 0; r < 2; r++) begin
      test_mid_reset(int'($urandom_range(H_TOTAL - 1, 0)),
                     int'($urandom_range(V_TOTAL - 1, 0)),
                     int'($urandom_range(5, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
